shift_rotate_seq: RTL and testbench

Parametrised, multi-cycle shift/rotate unit for the pipelined processor's execute stage, the successor to the 8-bit combinational shift/rotate block. It processes operands of any width `W` one bit position per clock, behind a valid/ready handshake. It adds rotate-through-carry operations and a carry input, and defines CF/OF for every operation and every count, including counts of zero and counts of `W` or more. Flags use the ALU's `{cf, zf, sf, of}` ordering.

---
 rtl/shift_rotate_seq.sv | 191 +++++++++++++++++++
 tb/tb_shift_rotate_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rotate_seq.sv
// Multi-cycle shift/rotate unit: one bit position per clock behind a valid/ready
// handshake, with rotate-through-carry and fully defined {cf, zf, sf, of} flags.
module shift_rotate_seq #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 2)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [2:0]   control,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] SRRes,
  output logic [3:0]   SRFlags
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STEP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_SAR = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b001;
  localparam logic [2:0] OP_SAL = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;
  localparam logic [2:0] OP_RCL = 3'b110;
  localparam logic [2:0] OP_RCR = 3'b111;

  localparam logic [W:0]    W_EXT   = (W + 1)'(W);
  localparam logic [W:0]    WP1_EXT = (W + 1)'(W + 1);
  localparam logic [CW-1:0] CNT_ONE = {{(CW - 1){1'b0}}, 1'b1};

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  d_q, d_d;
  logic          c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic          a_msb_q, a_msb_d;
  logic [W-1:0]  res_q, res_d;
  logic [3:0]    flags_q, flags_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic [W:0]    b_ext;
  logic [W:0]    n_ext;
  logic [CW-1:0] n_cnt;
  logic          init_c;
  logic [W-1:0]  step_d;
  logic          step_c;

  // of is forced low for a zero count; for shifts that matches A[W-1]^A[W-1] anyway.
  function automatic logic [3:0] flags_f(input logic [W-1:0] res, input logic cf,
                                         input logic [2:0] op, input logic a_msb,
                                         input logic n_zero);
    logic of;
    if (n_zero)
      of = 1'b0;
    else if (!op[2])
      of = a_msb ^ res[W-1];
    else if (!op[0])
      of = res[W-1] ^ cf;
    else
      of = res[W-1] ^ res[W-2];
    return {cf, (res == '0), res[W-1], of};
  endfunction

  always_comb begin
    b_ext = {1'b0, B};
    case (control[2:1])
      2'b10:   n_ext = b_ext % W_EXT;
      2'b11:   n_ext = b_ext % WP1_EXT;
      default: n_ext = (b_ext >= W_EXT) ? W_EXT : b_ext;
    endcase
    n_cnt  = n_ext[CW-1:0];
    init_c = (control[2:1] == 2'b11) ? cin : 1'b0;
  end

  always_comb begin
    step_d = d_q;
    step_c = c_q;
    case (op_q)
      OP_SAR: begin
        step_c = d_q[0];
        step_d = {d_q[W-1], d_q[W-1:1]};
      end
      OP_SHR: begin
        step_c = d_q[0];
        step_d = {1'b0, d_q[W-1:1]};
      end
      OP_SAL, OP_SHL: begin
        step_c = d_q[W-1];
        step_d = {d_q[W-2:0], 1'b0};
      end
      OP_ROL: begin
        step_c = d_q[W-1];
        step_d = {d_q[W-2:0], d_q[W-1]};
      end
      OP_ROR: begin
        step_c = d_q[0];
        step_d = {d_q[0], d_q[W-1:1]};
      end
      OP_RCL:  {step_c, step_d} = {d_q, c_q};
      OP_RCR:  {step_d, step_c} = {c_q, d_q};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_msb_d = a_msb_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          d_d     = A;
          c_d     = init_c;
          op_d    = control;
          a_msb_d = A[W-1];
          cnt_d   = n_cnt;
          if (n_cnt == '0) begin
            state_d = S_DONE;
            res_d   = A;
            flags_d = flags_f(A, init_c, control, A[W-1], 1'b1);
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        d_d   = step_d;
        c_d   = step_c;
        cnt_d = cnt_q - CNT_ONE;
        // The last step's result goes straight into the output registers.
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
          res_d   = step_d;
          flags_d = flags_f(step_d, step_c, op_q, a_msb_q, 1'b0);
        end
      end
      S_DONE: begin
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      d_q         <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      op_q        <= '0;
      a_msb_q     <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_msb_q     <= a_msb_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign SRRes     = res_q;
  assign SRFlags   = flags_q;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Bench for shift_rotate_seq at W=8, 16 and 2 against an arithmetic model of the
// shift/rotate rules, with directed vectors, backpressure and reset scenarios.
module tb_shift_rotate_seq;

  localparam logic [2:0] SAR = 3'b000, SHR = 3'b001, SAL = 3'b010, SHL = 3'b011;
  localparam logic [2:0] ROL = 3'b100, ROR = 3'b101, RCL = 3'b110, RCR = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        iv;
  logic        rdy_o;
  logic [15:0] a_s, b_s;
  logic [2:0]  ctl;
  logic        cin_s;
  int          sel;

  logic        in_ready8, out_valid8, in_ready16, out_valid16, in_ready2, out_valid2;
  logic [7:0]  res8;
  logic [15:0] res16;
  logic [1:0]  res2;
  logic [3:0]  fl8, fl16, fl2;

  logic        in_ready_m, out_valid_m;
  logic [15:0] res_m;
  logic [3:0]  fl_m;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          acc_cyc;
  bit          pending = 0;
  bit          lat_done;
  logic [15:0] exp_res;
  logic [3:0]  exp_flags;
  int          exp_n;
  logic [15:0] last_res;
  logic [3:0]  last_flags;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_rotate_seq #(.W(8)) u_w8 (
    .clk(clk), .reset(reset), .in_valid(iv && sel == 0), .in_ready(in_ready8),
    .A(a_s[7:0]), .B(b_s[7:0]), .control(ctl), .cin(cin_s),
    .out_valid(out_valid8), .out_ready(rdy_o), .SRRes(res8), .SRFlags(fl8));

  shift_rotate_seq #(.W(16)) u_w16 (
    .clk(clk), .reset(reset), .in_valid(iv && sel == 1), .in_ready(in_ready16),
    .A(a_s), .B(b_s), .control(ctl), .cin(cin_s),
    .out_valid(out_valid16), .out_ready(rdy_o), .SRRes(res16), .SRFlags(fl16));

  shift_rotate_seq #(.W(2)) u_w2 (
    .clk(clk), .reset(reset), .in_valid(iv && sel == 2), .in_ready(in_ready2),
    .A(a_s[1:0]), .B(b_s[1:0]), .control(ctl), .cin(cin_s),
    .out_valid(out_valid2), .out_ready(rdy_o), .SRRes(res2), .SRFlags(fl2));

  always_comb begin
    in_ready_m  = in_ready8;
    out_valid_m = out_valid8;
    res_m       = {8'h00, res8};
    fl_m        = fl8;
    if (sel == 1) begin
      in_ready_m  = in_ready16;
      out_valid_m = out_valid16;
      res_m       = res16;
      fl_m        = fl16;
    end else if (sel == 2) begin
      in_ready_m  = in_ready2;
      out_valid_m = out_valid2;
      res_m       = {14'h0000, res2};
      fl_m        = fl2;
    end
  end

  function automatic int w_of(input int s);
    return (s == 0) ? 8 : (s == 1) ? 16 : 2;
  endfunction

  function automatic int n_of(input int w, input logic [2:0] op, input longint b);
    if (op < 3'd4) return (b >= w) ? w : int'(b);
    if (op < 3'd6) return int'(b % w);
    return int'(b % (w + 1));
  endfunction

  // Result and flags from whole-word arithmetic: shifts, rotations of a W or W+1 bit value.
  function automatic logic [19:0] model(input int w, input logic [2:0] op,
                                        input logic [15:0] a16, input logic [15:0] b16,
                                        input logic ci);
    longint unsigned mask, m1, a, x, y, res;
    longint s;
    int n;
    logic cf, sf, of;
    mask = (64'd1 << w) - 1;
    m1   = (64'd1 << (w + 1)) - 1;
    a    = a16 & mask;
    n    = n_of(w, op, b16 & mask);
    res  = a;
    cf   = 1'b0;
    case (op)
      SAR: begin
        s   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        res = longint'(s >>> n) & mask;
        cf  = (n == 0) ? 1'b0 : s[n-1];
      end
      SHR: begin
        res = a >> n;
        cf  = (n == 0) ? 1'b0 : a[n-1];
      end
      SAL, SHL: begin
        res = (a << n) & mask;
        cf  = (n == 0) ? 1'b0 : a[w-n];
      end
      ROL: if (n != 0) begin
        res = ((a << n) | (a >> (w - n))) & mask;
        cf  = res[0];
      end
      ROR: if (n != 0) begin
        res = ((a >> n) | (a << (w - n))) & mask;
        cf  = res[w-1];
      end
      RCL: begin
        x   = (longint'(ci) << w) | a;
        y   = (n == 0) ? x : (((x << n) | (x >> (w + 1 - n))) & m1);
        res = y & mask;
        cf  = y[w];
      end
      default: begin
        x   = (a << 1) | longint'(ci);
        y   = (n == 0) ? x : (((x >> n) | (x << (w + 1 - n))) & m1);
        res = y >> 1;
        cf  = y[0];
      end
    endcase
    sf = res[w-1];
    if (n == 0)         of = 1'b0;
    else if (op < 3'd4) of = a[w-1] ^ sf;
    else if (!op[0])    of = sf ^ cf;
    else                of = sf ^ res[w-2];
    return {res[15:0], cf, (res == 0), sf, of};
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s (W=%0d): got 0x%0h expected 0x%0h", name, w_of(sel), act, req);
    end
  endtask

  // Single compare process: every cycle the result is valid it must match the model.
  always @(negedge clk) begin
    if (!reset && out_valid_m) begin
      if (!pending) begin
        check("unexpected_out_valid", out_valid_m, 0);
      end else begin
        check("res", res_m, exp_res);
        check("flags", fl_m, exp_flags);
        if (!lat_done) begin
          lat_done = 1;
          check("latency", cyc - acc_cyc + 1, exp_n + 1);
        end
      end
    end
  end

  task automatic do_op(input int s, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic ci, input int hold);
    int k;
    @(negedge clk);
    sel = s; a_s = a; b_s = b; ctl = op; cin_s = ci; rdy_o = 1'b0;
    check("in_ready_idle", in_ready_m, 1);
    {exp_res, exp_flags} = model(w_of(s), op, a, b, ci);
    exp_n = n_of(w_of(s), op, b & ((16'd1 << w_of(s)) - 16'd1));
    iv = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc; pending = 1; lat_done = 0; iv = 1'b0;
    a_s = ~a; b_s = ~b; ctl = ~op; cin_s = ~ci;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid_m && k < 40);
    check("out_valid_timeout", out_valid_m, 1);
    last_res = res_m;
    last_flags = fl_m;
    for (int i = 0; i < hold; i++) begin
      check("in_ready_busy", in_ready_m, 0);
      iv = (i == 0);
      @(negedge clk);
    end
    iv = 1'b0;
    rdy_o = 1'b1;
    @(posedge clk);
    #1;
    pending = 0; rdy_o = 1'b0;
    @(negedge clk);
    check("in_ready_after_done", in_ready_m, 1);
    check("no_stray_accept", out_valid_m, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [15:0] mask, ra, rb;
    reset = 1'b1; iv = 1'b0; rdy_o = 1'b0; a_s = '0; b_s = '0; ctl = '0; cin_s = 1'b0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      sel = s;
      #1;
      check("reset_in_ready", in_ready_m, 1);
      check("reset_out_valid", out_valid_m, 0);
      check("reset_res", res_m, 0);
      check("reset_flags", fl_m, 0);
    end

    check("model_shr", model(8, SHR, 16'h81, 16'd1, 1'b0), {16'h0040, 4'b1001});
    check("model_sar", model(8, SAR, 16'h80, 16'd9, 1'b0), {16'h00FF, 4'b1010});
    check("model_rol", model(8, ROL, 16'h81, 16'd9, 1'b0), {16'h0003, 4'b1001});
    check("model_ror0", model(8, ROR, 16'h5A, 16'd0, 1'b0), {16'h005A, 4'b0000});
    check("model_rcr", model(8, RCR, 16'h01, 16'd1, 1'b0), {16'h0000, 4'b1100});
    check("model_rcl0", model(8, RCL, 16'h00, 16'd9, 1'b1), {16'h0000, 4'b1100});

    do_op(0, SHR, 16'h81, 16'd1, 1'b0, 0);
    check("dir_shr_res", last_res, 16'h40);
    check("dir_shr_flags", last_flags, 4'b1001);
    do_op(0, SAR, 16'h80, 16'd9, 1'b0, 0);
    check("dir_sar_res", last_res, 16'hFF);
    check("dir_sar_flags", last_flags, 4'b1010);
    do_op(0, ROL, 16'h81, 16'd9, 1'b0, 0);
    check("dir_rol_res", last_res, 16'h03);
    check("dir_rol_flags", last_flags, 4'b1001);
    do_op(0, ROR, 16'h5A, 16'd0, 1'b0, 0);
    check("dir_ror_res", last_res, 16'h5A);
    check("dir_ror_flags", last_flags, 4'b0000);
    do_op(0, RCR, 16'h01, 16'd1, 1'b0, 0);
    check("dir_rcr_res", last_res, 16'h00);
    check("dir_rcr_flags", last_flags, 4'b1100);
    do_op(0, RCL, 16'h00, 16'd9, 1'b1, 0);
    check("dir_rcl_res", last_res, 16'h00);
    check("dir_rcl_flags", last_flags, 4'b1100);
    do_op(0, RCL, 16'hA5, 16'd8, 1'b1, 3);
    do_op(0, SHL, 16'hC3, 16'd200, 1'b0, 3);

    // Reset during STEP.
    @(negedge clk);
    sel = 0; a_s = 16'h00F0; b_s = 16'd5; ctl = SHL; cin_s = 1'b0; iv = 1'b1;
    @(posedge clk);
    #1;
    iv = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid_m, 0);
    check("rst_mid_in_ready", in_ready_m, 1);
    check("rst_mid_res", res_m, 0);
    check("rst_mid_flags", fl_m, 0);
    do_op(0, SHL, 16'h01, 16'd3, 1'b0, 0);
    check("after_reset_shl", last_res, 16'h08);

    // Reset and accept on the same edge: the operation is dropped.
    @(negedge clk);
    a_s = 16'h0033; b_s = 16'd0; ctl = SHR; iv = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1;
    iv = 1'b0; reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_accept_dropped", out_valid_m, 0);
    end

    for (int s = 1; s < 3; s++) begin
      w = w_of(s);
      mask = (16'd1 << w) - 16'd1;
      for (int i = 0; i < 60; i++) begin
        ra = 16'($urandom) & mask;
        rb = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 2 * w + 2)) & mask
                                         : 16'($urandom) & mask;
        do_op(s, 3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)),
              $urandom_range(0, 2));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
